// File: rtl/uc_multicycle.sv
// uc_multicycle: multicycle control unit for a small 16-bit datapath.
// Each instruction walks FETCH -> DECODE -> EXEC; a HALT opcode parks the
// FSM in HALT until reset. EXEC strobes come combinationally from the
// opcode latched on the edge that leaves DECODE.
module uc_multicycle (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       zero,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we,
  output logic       wez,
  output logic [2:0] ALUOp,
  output logic       pc_en,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [5:0] op;

  // Opcode classes, derived from the latched opcode only.
  logic is_alu;
  logic is_li;
  logic is_j;
  logic is_jz;
  logic is_jnz;
  logic is_halt;
  logic is_illegal;

  assign is_alu     = op[5];
  assign is_li      = (op[5:2] == 4'b0000);
  assign is_j       = (op == 6'b000100);
  assign is_jz      = (op == 6'b000101);
  assign is_jnz     = (op == 6'b000110);
  assign is_halt    = (op == 6'b000111);
  assign is_illegal = ~op[5] & (op[4:3] != 2'b00);

  // State register; reset drops straight to FETCH, aborting any EXEC strobes.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Opcode latch, captured on the edge that leaves DECODE (memory data valid).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                op <= 6'b000000;
    else if (state == DECODE) op <= Opcode;
  end

  // Next-state and strobe decode.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    s_inc      = 1'b1;
    s_inm      = 1'b0;
    we         = 1'b0;
    wez        = 1'b0;
    ALUOp      = 3'b000;
    pc_en      = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;

    unique case (state)
      FETCH: begin
        state_next = DECODE;
      end

      DECODE: begin
        state_next = EXEC;
      end

      EXEC: begin
        state_next = FETCH;
        pc_en      = 1'b1;
        if (is_alu) begin
          we    = 1'b1;
          wez   = 1'b1;
          ALUOp = op[4:2];
        end else if (is_li) begin
          we    = 1'b1;
          s_inm = 1'b1;
        end else if (is_j) begin
          s_inc = 1'b0;
        end else if (is_jz) begin
          s_inc = ~zero;
        end else if (is_jnz) begin
          s_inc = zero;
        end else if (is_halt) begin
          // The PC stays on the HALT instruction; no further fetches.
          pc_en      = 1'b0;
          state_next = HALT;
        end else if (is_illegal) begin
          // Undefined opcode: behave as a NOP and flag it for this cycle.
          illegal = 1'b1;
        end
      end

      HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_uc_multicycle.sv
// tb_uc_multicycle: scoreboard bench for uc_multicycle. Per-cycle expected
// output vectors are queued when an instruction is driven and popped as the
// DUT is sampled on the falling edge.
module tb_uc_multicycle;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic       zero;
  logic       s_inc;
  logic       s_inm;
  logic       we;
  logic       wez;
  logic [2:0] ALUOp;
  logic       pc_en;
  logic       halted;
  logic       illegal;

  uc_multicycle dut (
    .clk     (clk),
    .reset   (reset),
    .Opcode  (Opcode),
    .zero    (zero),
    .s_inc   (s_inc),
    .s_inm   (s_inm),
    .we      (we),
    .wez     (wez),
    .ALUOp   (ALUOp),
    .pc_en   (pc_en),
    .halted  (halted),
    .illegal (illegal)
  );

  // Output vector layout: {s_inc, s_inm, we, wez, ALUOp[2:0], pc_en, halted, illegal}
  typedef logic [9:0] outv_t;

  typedef struct {
    string tag;
    outv_t v;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  localparam outv_t IDLE_V = {1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
  localparam outv_t HALT_V = {1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time=%0t required<200000)", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic outv_t dut_v();
    return {s_inc, s_inm, we, wez, ALUOp, pc_en, halted, illegal};
  endfunction

  task automatic check(input string tag, input outv_t act, input outv_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b (s_inc s_inm we wez ALUOp pc_en halted illegal)",
               tag, act, exp);
    end
  endtask

  // Reference behaviour of the EXEC cycle for one opcode and zero flag.
  function automatic outv_t exec_model(input logic [5:0] op, input logic z);
    outv_t r;
    casez (op)
      6'b1?????: r = {1'b1, 1'b0, 1'b1, 1'b1, op[4:2], 1'b1, 1'b0, 1'b0};
      6'b0000??: r = {1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0};
      6'b000100: r = {1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0};
      6'b000101: r = {~z,   1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0};
      6'b000110: r = {z,    1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0};
      6'b000111: r = {1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
      default:   r = {1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1};
    endcase
    return r;
  endfunction

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: got empty queue required an entry");
    end else begin
      e = exp_q.pop_front();
      check(e.tag, dut_v(), e.v);
    end
  endtask

  // Entered just after a rising edge with the FSM in FETCH. Runs one full
  // instruction; Opcode is scrambled after DECODE to prove EXEC uses the latch.
  task automatic run_instr(input string name, input logic [5:0] op, input logic z);
    Opcode = op;
    zero   = z;
    exp_q.push_back('{tag: {name, "_fetch"},  v: IDLE_V});
    exp_q.push_back('{tag: {name, "_decode"}, v: IDLE_V});
    exp_q.push_back('{tag: {name, "_exec"},   v: exec_model(op, z)});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pop_check();
      @(posedge clk);
      #1;
      if (i == 1) Opcode = op ^ 6'b111111;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    Opcode   = 6'b000000;
    zero     = 1'b0;

    #2;
    check("reset_state", dut_v(), IDLE_V);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Main decode coverage.
    run_instr("alu_100101", 6'b100101, 1'b0);
    run_instr("alu_111110", 6'b111110, 1'b1);
    run_instr("li_000000",  6'b000000, 1'b0);
    run_instr("li_000011",  6'b000011, 1'b1);
    run_instr("j",          6'b000100, 1'b1);
    run_instr("jz_z1",      6'b000101, 1'b1);
    run_instr("jz_z0",      6'b000101, 1'b0);
    run_instr("jnz_z1",     6'b000110, 1'b1);
    run_instr("jnz_z0",     6'b000110, 1'b0);
    run_instr("ill_001000", 6'b001000, 1'b0);
    run_instr("ill_011111", 6'b011111, 1'b1);

    // Reset asserted mid-EXEC, between edges: strobes must drop at once.
    Opcode = 6'b100101;
    zero   = 1'b0;
    exp_q.push_back('{tag: "rexec_fetch",  v: IDLE_V});
    exp_q.push_back('{tag: "rexec_decode", v: IDLE_V});
    exp_q.push_back('{tag: "rexec_exec",   v: exec_model(6'b100101, 1'b0)});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pop_check();
      if (i < 2) begin
        @(posedge clk);
        #1;
      end
    end
    #1;
    reset = 1'b1;
    #1;
    check("rexec_async_drop", dut_v(), IDLE_V);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_instr("after_rexec_li", 6'b000000, 1'b0);

    // HALT: parks with halted=1 and pc_en=0 until reset.
    run_instr("halt", 6'b000111, 1'b0);
    for (int i = 0; i < 12; i++) exp_q.push_back('{tag: "halt_hold", v: HALT_V});
    for (int i = 0; i < 12; i++) begin
      Opcode = 6'($urandom_range(0, 63));
      zero   = 1'($urandom_range(0, 1));
      @(negedge clk);
      pop_check();
    end
    #1;
    reset = 1'b1;
    #1;
    check("halt_reset_async", dut_v(), IDLE_V);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_instr("post_halt_alu", 6'b101001, 1'b0);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d leftover required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uc_multicycle.md
UC_MULTICYCLE -- requirements
Module: uc_multicycle

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The module SHALL have port Opcode, input, 6 bits: instruction[15:10] from the datapath program memory.
REQ-004 The module SHALL have port zero, input, 1 bit: registered zero flag from the datapath.
REQ-005 The module SHALL have port s_inc, output, 1 bit: PC mux select; 1 selects PC+1, 0 selects the jump address.
REQ-006 The module SHALL have port s_inm, output, 1 bit: write-data select; 1 selects the immediate, 0 selects the ALU result.
REQ-007 The module SHALL have port we, output, 1 bit: register-file write enable.
REQ-008 The module SHALL have port wez, output, 1 bit: zero-flag write enable.
REQ-009 The module SHALL have port ALUOp, output, 3 bits: ALU operation select.
REQ-010 The module SHALL have port pc_en, output, 1 bit: PC load enable; the PC holds when it is 0.
REQ-011 The module SHALL have port halted, output, 1 bit: high while in the HALT state.
REQ-012 The module SHALL have port illegal, output, 1 bit: one-cycle pulse on an undefined opcode.

Function
REQ-013 Decode of the latched opcode op SHALL be as follows:
- op[5]=1: ALU instruction, with ALUOp=op[4:2].
- op[5:2]=0000: LI (load immediate).
- op=000100: J (jump).
- op=000101: JZ (jump if zero).
- op=000110: JNZ (jump if not zero).
- op=000111: HALT.
- Any other op: illegal.
REQ-014 The FSM SHALL have the states FETCH, DECODE, EXEC and HALT; the state register SHALL be the only sequential element besides the opcode latch.
REQ-015 FETCH SHALL last one cycle, with all strobes 0 and pc_en=0, while the synchronous program memory reads; next state DECODE.
REQ-016 DECODE SHALL latch Opcode into an internal 6-bit register at the clock edge that leaves DECODE, with all strobes 0; next state EXEC.
REQ-017 EXEC SHALL last exactly one cycle and drive its strobes combinationally from the latched opcode; next state FETCH, or HALT for a HALT opcode.
REQ-018 In EXEC, an ALU instruction SHALL drive we=1, wez=1, s_inm=0, s_inc=1 and pc_en=1.
REQ-019 In EXEC, LI SHALL drive we=1, wez=0, s_inm=1, s_inc=1 and pc_en=1.
REQ-020 In EXEC, J SHALL drive s_inc=0, pc_en=1, we=0 and wez=0.
REQ-021 In EXEC, JZ SHALL drive s_inc=~zero and JNZ SHALL drive s_inc=zero, each with pc_en=1; zero is sampled combinationally during EXEC.
REQ-022 In EXEC, an illegal opcode SHALL act as a NOP (s_inc=1, pc_en=1, we=0, wez=0) and SHALL raise illegal=1 for that cycle only.
REQ-023 HALT SHALL drive pc_en=0, we=0, wez=0 and halted=1, and SHALL be left only by reset.
REQ-024 Outside EXEC, ALUOp SHALL be 000, s_inm SHALL be 0 and s_inc SHALL be 1.
REQ-025 Every non-halting instruction SHALL take exactly 3 cycles (FETCH, DECODE, EXEC) with exactly one pc_en pulse per instruction.
REQ-026 we and wez SHALL never be 1 outside EXEC.

Reset
REQ-027 Asserting reset SHALL immediately, without waiting for clk, set the state to FETCH and the opcode latch to 000000, giving outputs s_inc=1 and s_inm=we=wez=pc_en=halted=illegal=0, ALUOp=000.
REQ-028 A reset asserted during EXEC SHALL abort the strobes in the same cycle, with no write or PC update at the following edge.
REQ-029 After reset deasserts, the first rising edge SHALL move the FSM from FETCH to DECODE.

Verification
REQ-030 The bench SHALL check: Opcode=100101 (ALU, ALUOp 001) after reset -> cycle 3: we=1, wez=1, s_inm=0, ALUOp=001, pc_en=1; cycles 1-2: all strobes 0.
REQ-031 The bench SHALL check: LI (000000) -> in EXEC, we=1, s_inm=1, wez=0.
REQ-032 The bench SHALL check: JZ with zero=1 -> s_inc=0, pc_en=1; JZ with zero=0 -> s_inc=1; JNZ with zero=1 -> s_inc=1.
REQ-033 The bench SHALL check: Opcode=001000 -> illegal=1 only in EXEC, we=0, and pc_en=1 with s_inc=1.
REQ-034 The bench SHALL check: HALT (000111) -> halted=1 and pc_en=0 held for 10+ cycles; a reset pulse then returns to FETCH with halted=0.
REQ-035 The bench SHALL check: reset asserted mid-EXEC, between clock edges -> we and pc_en drop to 0 without a clock edge, and the next instruction begins in FETCH.
